serial_frame_ctrl: RTL

Frame-level controller that sits directly behind the serial receiver. It turns the receiver's byte-complete level into byte events and parses framed packets: sync byte, length, payload, checksum. Good payloads are buffered and streamed out over a valid/ready port. The block also owns the receiver's reset and pulses it to resynchronise the line after an inter-byte timeout.

---
 rtl/serial_frame_pkg.sv | 28 ++
 rtl/serial_frame_buf.sv | 59 +++++
 rtl/serial_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared state encoding, error codes and helpers for the serial frame controller.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DRAIN   = 3'd4
    } frame_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // A single-entry buffer still needs a one-bit pointer to exist.
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_frame_buf.sv
// Payload buffer: register array with synchronous write, combinational read,
// and the write/read pointers that walk it.
module serial_frame_buf
    import serial_frame_pkg::*;
#(
    parameter int Width  = 8,
    parameter int MaxLen = 16,
    parameter int PtrW   = ptr_width(MaxLen)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_clr,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_clr,
    input  logic             rd_adv,
    output logic [PtrW-1:0]  wr_ptr,
    output logic [PtrW-1:0]  rd_ptr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem_r [MaxLen];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;

    // Write pointer: cleared at frame start, advanced per stored byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
        end else if (wr_clr) begin
            wr_ptr_r <= '0;
        end else if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + PtrW'(1);
        end
    end

    // Read pointer: cleared when a frame is accepted, advanced per transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_r <= '0;
        end else if (rd_clr) begin
            rd_ptr_r <= '0;
        end else if (rd_adv) begin
            rd_ptr_r <= rd_ptr_r + PtrW'(1);
        end
    end

    // Storage array; contents are only observed while draining.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign wr_ptr  = wr_ptr_r;
    assign rd_ptr  = rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/serial_frame_ctrl.sv
// Frame parser behind the serial receiver: byte-event detection, sync/len/payload/
// checksum FSM, inter-byte timeout with receiver reset, and buffered payload output.
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int                    Width      = 8,
    parameter int                    MaxLen     = 16,
    parameter logic [Width-1:0]      SyncByte   = Width'(DEFAULT_SYNC_BYTE),
    parameter int                    TimerWidth = 16,
    parameter logic [TimerWidth-1:0] Timeout    = TimerWidth'(16'd50000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] rx_q,
    input  logic             rx_finish,
    output logic             rx_rst,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [7:0]       drop_cnt
);

    localparam int                    PtrW    = ptr_width(MaxLen);
    localparam logic [TimerWidth-1:0] TmoLast = Timeout - TimerWidth'(1);
    localparam logic [Width-1:0]      MaxLenW = Width'(MaxLen);

    // Modular checksum accumulate.
    function automatic logic [Width-1:0] csum_add(input logic [Width-1:0] acc,
                                                  input logic [Width-1:0] data);
        return acc + data;
    endfunction

    frame_state_e          state_r;
    frame_state_e          state_nxt_s;
    logic                  finish_d_r;
    logic                  byte_ev_s;
    logic [Width-1:0]      len_r;
    logic [Width-1:0]      sum_r;
    logic [Width-1:0]      sum_nxt_s;
    logic [TimerWidth-1:0] timer_r;
    logic [TimerWidth-1:0] timer_nxt_s;
    logic                  timing_s;
    logic                  tmo_hit_s;
    logic                  len_bad_s;
    logic                  wr_last_s;
    logic                  rd_last_s;
    logic                  len_ld_s;
    logic                  wr_clr_s;
    logic                  wr_en_s;
    logic                  rd_clr_s;
    logic                  rd_adv_s;
    logic                  ok_set_s;
    logic                  err_set_s;
    logic [1:0]            err_code_s;
    logic                  rx_rst_set_s;
    logic                  drop_s;
    logic [PtrW-1:0]       wr_ptr_s;
    logic [PtrW-1:0]       rd_ptr_s;
    logic [Width-1:0]      rd_data_s;
    logic                  frame_ok_r;
    logic                  frame_err_r;
    logic [1:0]            err_code_r;
    logic                  rx_rst_r;
    logic [7:0]            drop_cnt_r;

    serial_frame_buf #(
        .Width  (Width),
        .MaxLen (MaxLen),
        .PtrW   (PtrW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_clr  (wr_clr_s),
        .wr_en   (wr_en_s),
        .wr_data (rx_q),
        .rd_clr  (rd_clr_s),
        .rd_adv  (rd_adv_s),
        .wr_ptr  (wr_ptr_s),
        .rd_ptr  (rd_ptr_s),
        .rd_data (rd_data_s)
    );

    assign byte_ev_s = rx_finish & ~finish_d_r;
    assign timing_s  = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
    assign tmo_hit_s = (timer_r == TmoLast);
    assign len_bad_s = (rx_q == {Width{1'b0}}) || (rx_q > MaxLenW);
    assign wr_last_s = (Width'(wr_ptr_s) == (len_r - Width'(1)));
    assign rd_last_s = (Width'(rd_ptr_s) == (len_r - Width'(1)));

    // Next-state, datapath strobes and status pulses for the frame parser.
    always_comb begin
        state_nxt_s  = state_r;
        sum_nxt_s    = sum_r;
        timer_nxt_s  = '0;
        len_ld_s     = 1'b0;
        wr_clr_s     = 1'b0;
        wr_en_s      = 1'b0;
        rd_clr_s     = 1'b0;
        rd_adv_s     = 1'b0;
        ok_set_s     = 1'b0;
        err_set_s    = 1'b0;
        err_code_s   = ERR_NONE;
        rx_rst_set_s = 1'b0;
        drop_s       = 1'b0;

        case (state_r)
            ST_HUNT: begin
                if (byte_ev_s && (rx_q == SyncByte)) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (byte_ev_s) begin
                    len_ld_s  = 1'b1;
                    sum_nxt_s = rx_q;
                    if (len_bad_s) begin
                        err_set_s   = 1'b1;
                        err_code_s  = ERR_LEN;
                        state_nxt_s = ST_HUNT;
                    end else begin
                        wr_clr_s    = 1'b1;
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (byte_ev_s) begin
                    wr_en_s   = 1'b1;
                    sum_nxt_s = csum_add(sum_r, rx_q);
                    if (wr_last_s) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (byte_ev_s) begin
                    if (rx_q == sum_r) begin
                        ok_set_s    = 1'b1;
                        rd_clr_s    = 1'b1;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        err_set_s   = 1'b1;
                        err_code_s  = ERR_CHK;
                        state_nxt_s = ST_HUNT;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_DRAIN: begin
                drop_s = byte_ev_s;
                if (out_ready) begin
                    rd_adv_s = 1'b1;
                    if (rd_last_s) begin
                        state_nxt_s = ST_HUNT;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
            end
        endcase

        // A byte event always beats a coincident timeout and restarts the timer.
        if (timing_s && !byte_ev_s) begin
            if (tmo_hit_s) begin
                err_set_s    = 1'b1;
                err_code_s   = ERR_TMO;
                rx_rst_set_s = 1'b1;
                state_nxt_s  = ST_HUNT;
            end else begin
                timer_nxt_s = timer_r + TimerWidth'(1);
            end
        end else begin
            timer_nxt_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Edge-detect history (reset high to mask a held finish), timer, checksum, length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            finish_d_r <= 1'b1;
            timer_r    <= '0;
            sum_r      <= '0;
            len_r      <= '0;
        end else begin
            finish_d_r <= rx_finish;
            timer_r    <= timer_nxt_s;
            sum_r      <= sum_nxt_s;
            if (len_ld_s) begin
                len_r <= rx_q;
            end
        end
    end

    // Registered status pulses, receiver reset and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            rx_rst_r    <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            frame_ok_r  <= ok_set_s;
            frame_err_r <= err_set_s;
            err_code_r  <= err_code_s;
            rx_rst_r    <= rx_rst_set_s;
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign out_valid = (state_r == ST_DRAIN);
    assign out_data  = out_valid ? rd_data_s : {Width{1'b0}};
    assign out_last  = out_valid && rd_last_s;
    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;
    assign rx_rst    = rx_rst_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
